uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
//
// PURPOSE
//   Synthesizable, parametrised UART receiver with a receive FIFO, used as the
//   on-chip capture path for the slurm16 serial link. It supports configurable
//   data width, parity and FIFO depth, detects framing, parity and overrun
//   errors, and rejects start-bit glitches. Received words are presented on a
//   first-word-fall-through valid/ready read port for the CPU peripheral bus.
//
// PARAMETERS
//   CLOCK_FREQ  10000000  system clock frequency in Hz
//   BAUD        115200    line rate in bit/s
//   DATA_BITS   8         data bits per frame (5..9), sent LSB first
//   PARITY      0         0 = none, 1 = odd, 2 = even
//   FIFO_DEPTH  16        receive FIFO entries; must be a power of 2, >= 2
//
// PORTS
//   CLK         in   1                      system clock, rising edge
//   RSTb        in   1                      asynchronous reset, active low
//   rx          in   1                      serial input, asynchronous to CLK, idle high
//   rd_data     out  DATA_BITS              FIFO head word
//   rd_valid    out  1                      FIFO not empty
//   rd_ready    in   1                      pop the head when rd_valid is high
//   fifo_count  out  $clog2(FIFO_DEPTH)+1   number of occupied entries
//   frame_err   out  1                      sticky: stop bit sampled low
//   parity_err  out  1                      sticky: parity mismatch
//   overrun     out  1                      sticky: word dropped because the FIFO was full
//   err_clr     in   1                      clears all sticky flags (one-cycle pulse)
//
// BEHAVIOUR
//   Reset
//   - RSTb low clears all state asynchronously.
//   - Reset values: rd_valid = 0, rd_data = 0, fifo_count = 0, all flags = 0,
//     FSM = IDLE, synchroniser flops = 1.
//   - Asserting RSTb mid-frame discards the partial frame and empties the FIFO.
//
//   Input synchroniser and bit timing
//   - rx passes through a 2-flop synchroniser, so it reaches the FSM 2 cycles late.
//   - BIT = CLOCK_FREQ/BAUD (integer; 86 at the defaults) and HALF = BIT/2.
//   - A bit counter runs from 0 to BIT-1 within every bit.
//   - Each bit value is the majority of the synchronised rx at counts HALF-1,
//     HALF and HALF+1.
//
//   State machine
//   - IDLE: on synchronised rx 1->0, clear the counter and go to START.
//   - START: at count HALF+1, if the majority vote is 1 (glitch), return to IDLE
//     with no flags set. Otherwise go to DATA when the counter wraps.
//   - DATA: shift DATA_BITS bits LSB first. Then go to PAR if PARITY != 0,
//     else to STOP.
//   - PAR: sample the parity bit.
//     - Odd parity: data bits plus parity bit have an odd number of 1s.
//     - Even parity: they have an even number of 1s.
//   - STOP: evaluate at count HALF+1.
//     - Stop bit 0: set frame_err and drop the word. Go to BREAK.
//     - Stop bit 1 and parity bad: set parity_err and drop the word. Go to IDLE.
//     - Stop bit 1 and parity good: push the word and go to IDLE.
//     - The FSM does not wait for the rest of the stop bit, so back-to-back
//       frames are accepted.
//   - BREAK: wait until synchronised rx is 1, then go to IDLE.
//     A held-low line yields exactly one frame_err.
//   - When both the stop bit and parity fail, only frame_err is set.
//
//   FIFO
//   - Push happens in the cycle after the STOP evaluation.
//   - rd_valid, rd_data and fifo_count update on the clock edge after the push.
//     From an empty FIFO, rd_valid rises 2 cycles after the STOP evaluation.
//   - rd_data is the head word whenever rd_valid = 1; it holds its last value
//     when the FIFO is empty.
//   - Pop happens when rd_valid && rd_ready. rd_ready while empty is ignored.
//   - Push while full (and no pop in the same cycle): the new word is dropped,
//     overrun is set and the contents are unchanged.
//   - Push and pop in the same cycle: both occur and fifo_count is unchanged.
//     This includes the full case, which does not set overrun.
//   - Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo
//     FIFO_DEPTH.
//
//   Flags
//   - Each flag stays set until err_clr.
//   - If a new error event occurs in the same cycle as err_clr, the flag ends
//     the cycle set (set wins).
//
// TESTING
//   Defaults: BIT = 86 cycles. Frames are driven at exactly 1/115200 s per bit.
//   1. 8N1 byte 0x55, then 0x41 back-to-back -> rd_data 0x55 then 0x41,
//      fifo_count 2, no flags.
//   2. PARITY=2: 0xA5 with parity 0 -> accepted; 0xA5 with parity 1 -> no push,
//      parity_err = 1.
//   3. 0x3C with stop bit 0, rx held low 2 bit times -> one frame_err, no push.
//      Then 0x7E -> accepted.
//   4. 17 bytes 0x00..0x10 with rd_ready = 0 -> fifo_count 16, overrun = 1,
//      reads return 0x00..0x0F. Then err_clr -> overrun = 0.
//   5. 20-cycle low pulse on rx -> no push, no flags, FSM back to IDLE.
//   6. RSTb low mid-way through bit 4 of a frame, released, then 0x99 sent ->
//      only 0x99 received, fifo_count 1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with majority-voted bit sampling, start-glitch rejection and a
// first-word-fall-through receive FIFO with sticky framing/parity/overrun flags.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int CLOCK_FREQ = 10000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          CLK,
    input  logic                          RSTb,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    input  logic                          err_clr
);

    localparam int BIT  = CLOCK_FREQ / BAUD;
    localparam int HALF = BIT / 2;
    localparam int CW   = $clog2(BIT);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int FW   = AW + 1;

    localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
    localparam logic [CW-1:0] CNT_EVAL = CW'(HALF + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT - 1);
    localparam logic [3:0]    IDX_LAST = 4'(DATA_BITS - 1);
    localparam logic [FW-1:0] CNT_FULL = FW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4,
        S_BREAK = 3'd5
    } state_t;

    function automatic logic parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
        logic ones_odd;
        ones_odd = ^{d, p};
        if (PARITY == 1) begin
            return ones_odd;
        end else if (PARITY == 2) begin
            return ~ones_odd;
        end else begin
            return 1'b1;
        end
    endfunction

    logic                  r_rx_meta, r_rx_sync, r_rx_prev;
    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [3:0]            r_bit_idx;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_s0, r_s1, r_par_bit;
    logic                  r_push;
    logic [DATA_BITS-1:0]  r_push_data;

    logic [DATA_BITS-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [FW-1:0]         r_count;
    logic                  r_valid;
    logic [DATA_BITS-1:0]  r_rd_data;
    logic                  r_frame_err, r_parity_err, r_overrun;

    logic                  w_maj, w_eval, w_par_ok;
    logic                  w_frame_ev, w_par_ev, w_ovr_ev;
    logic                  w_pop, w_full, w_wr;
    logic [AW-1:0]         w_rd_ptr_inc;
    logic [FW-1:0]         w_count_nxt;
    logic [DATA_BITS-1:0]  w_head_nxt;

    assign w_maj      = (r_s0 & r_s1) | (r_s0 & r_rx_sync) | (r_s1 & r_rx_sync);
    assign w_eval     = (r_cnt == CNT_EVAL);
    assign w_par_ok   = parity_ok(r_shift, r_par_bit);
    assign w_frame_ev = (r_state == S_STOP) && w_eval && !w_maj;
    assign w_par_ev   = (r_state == S_STOP) && w_eval && w_maj && !w_par_ok;

    assign w_pop        = r_valid && rd_ready;
    assign w_full       = (r_count == CNT_FULL);
    assign w_wr         = r_push && (!w_full || w_pop);
    assign w_ovr_ev     = r_push && w_full && !w_pop;
    assign w_rd_ptr_inc = r_rd_ptr + AW'(1);

    // Two-flop synchroniser plus delayed copy for falling-edge detection
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Receive FSM: bit timing, majority sampling, frame evaluation
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= 4'd0;
            r_shift     <= '0;
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            r_par_bit   <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_push <= 1'b0;
            if (r_cnt == CNT_S0) r_s0 <= r_rx_sync;
            if (r_cnt == CNT_S1) r_s1 <= r_rx_sync;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (r_rx_prev && !r_rx_sync) r_state <= S_START;
                end
                S_START: begin
                    if (w_eval && w_maj) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_cnt     <= '0;
                        r_bit_idx <= 4'd0;
                        r_state   <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_eval) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (r_bit_idx == IDX_LAST) begin
                            r_state <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_PAR: begin
                    if (w_eval) r_par_bit <= w_maj;
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    // Decide at mid stop bit so a following start edge is not missed
                    if (w_eval) begin
                        r_cnt <= '0;
                        if (!w_maj) begin
                            r_state <= S_BREAK;
                        end else begin
                            r_state <= S_IDLE;
                            if (w_par_ok) begin
                                r_push      <= 1'b1;
                                r_push_data <= r_shift;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_BREAK: begin
                    r_cnt <= '0;
                    if (r_rx_sync) r_state <= S_IDLE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Next occupancy and next head word of the FIFO
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_nxt = r_count + FW'(1);
            2'b01:   w_count_nxt = r_count - FW'(1);
            default: w_count_nxt = r_count;
        endcase
        w_head_nxt = r_rd_data;
        if (w_pop) begin
            if (r_count > FW'(1)) begin
                w_head_nxt = r_mem[w_rd_ptr_inc];
            end else if (w_wr) begin
                w_head_nxt = r_push_data;
            end else begin
                w_head_nxt = r_rd_data;
            end
        end else if (w_wr && (r_count == '0)) begin
            w_head_nxt = r_push_data;
        end else begin
            w_head_nxt = r_rd_data;
        end
    end

    // FIFO storage
    always_ff @(posedge CLK) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_push_data;
    end

    // FIFO pointers, occupancy and registered read port
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_rd_data <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= w_rd_ptr_inc;
            r_count   <= w_count_nxt;
            r_valid   <= (w_count_nxt != '0);
            r_rd_data <= w_head_nxt;
        end
    end

    // Sticky error flags; a new event wins over a simultaneous clear
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err  <= w_frame_ev | (r_frame_err  & ~err_clr);
            r_parity_err <= w_par_ev   | (r_parity_err & ~err_clr);
            r_overrun    <= w_ovr_ev   | (r_overrun    & ~err_clr);
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_valid   = r_valid;
    assign fifo_count = r_count;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;

endmodule
